// File: rtl/aes_sbox_rnd_gen_if.sv
// Randomness interface between the AES control side (master) and the masked
// S-box randomness producer (slave): seed handshake, stepping enable and the four S-box buses.
interface aes_sbox_rnd_gen_if #(
  parameter int unsigned D          = 2,
  parameter int unsigned BLIND_BITS = 24
);
  localparam int unsigned B0 = 2*D*(D-1);
  localparam int unsigned B1 = D*(D-1);
  localparam int unsigned B2 = 2*D*(D-1) + BLIND_BITS;
  localparam int unsigned B3 = 4*D*(D-1);

  logic          seed_valid;
  logic          seed_ready;
  logic [31:0]   seed_in;
  logic          rnd_en;
  logic          rnd_valid;
  logic          seed_err;
  logic [B0-1:0] rnd_bus0w;
  logic [B1-1:0] rnd_bus1w;
  logic [B2-1:0] rnd_bus2w;
  logic [B3-1:0] rnd_bus3w;

  modport master (
    output seed_valid, seed_in, rnd_en,
    input  seed_ready, rnd_valid, seed_err,
    input  rnd_bus0w, rnd_bus1w, rnd_bus2w, rnd_bus3w
  );

  modport slave (
    input  seed_valid, seed_in, rnd_en,
    output seed_ready, rnd_valid, seed_err,
    output rnd_bus0w, rnd_bus1w, rnd_bus2w, rnd_bus3w
  );
endinterface

// File: rtl/aes_sbox_rnd_gen.sv
// Masking randomness producer for the DOM S-box: 128-bit LFSR unrolled OUT_W steps per cycle,
// seeded by a 4-word handshake, warmed up, then stepped on demand into registered buses.
module aes_sbox_rnd_gen #(
  parameter int unsigned D          = 2,
  parameter int unsigned BLIND_BITS = 24,
  parameter int unsigned WARMUP_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  aes_sbox_rnd_gen_if.slave rnd
);
  localparam int unsigned B0     = 2*D*(D-1);
  localparam int unsigned B1     = D*(D-1);
  localparam int unsigned B2     = 2*D*(D-1) + BLIND_BITS;
  localparam int unsigned B3     = 4*D*(D-1);
  localparam int unsigned OUT_W  = B0 + B1 + B2 + B3;
  localparam int unsigned WCNT_W = (WARMUP_CYC > 0) ? $clog2(WARMUP_CYC + 1) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WARMUP_CYC);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WARMUP, ST_RUN} state_e;

  state_e             state_q, state_d;
  logic [127:0]       lfsr_q, lfsr_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic [OUT_W-1:0]   bus_q, bus_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               ready_q, ready_d;

  logic [127:0]       blk_s;
  logic [OUT_W-1:0]   blk_f;
  logic [127:0]       seed_wr;
  logic               accept;

  // One block = OUT_W chained LFSR steps; F[k] is the feedback bit of step k.
  always_comb begin
    logic fb;
    blk_s = lfsr_q;
    blk_f = '0;
    fb    = 1'b0;
    for (int unsigned k = 0; k < OUT_W; k++) begin
      fb       = blk_s[127] ^ blk_s[125] ^ blk_s[100] ^ blk_s[98];
      blk_f[k] = fb;
      blk_s    = {blk_s[126:0], fb};
    end
  end

  always_comb begin
    seed_wr = lfsr_q;
    seed_wr[{cnt_q, 5'b0} +: 32] = rnd.seed_in;
  end

  assign accept = rnd.seed_valid & ready_q;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    bus_d   = bus_q;
    valid_d = valid_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          lfsr_d  = seed_wr;
          cnt_d   = cnt_q + 2'd1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          lfsr_d = seed_wr;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = ST_WARMUP;
            // An all-zero state would lock the LFSR; substitute a single set bit.
            if (seed_wr == '0) begin
              lfsr_d = 128'h1;
              err_d  = 1'b1;
            end else begin
              err_d  = 1'b0;
            end
          end
        end
      end
      ST_WARMUP: begin
        lfsr_d = blk_s;
        if (wcnt_q == WCNT_LAST) begin
          bus_d   = blk_f;
          valid_d = 1'b1;
          wcnt_d  = '0;
          state_d = ST_RUN;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      ST_RUN: begin
        // A seed word outranks stepping: the old stream is abandoned without advancing.
        if (accept) begin
          lfsr_d  = seed_wr;
          cnt_d   = cnt_q + 2'd1;
          valid_d = 1'b0;
          state_d = ST_LOAD;
        end else if (rnd.rnd_en) begin
          lfsr_d = blk_s;
          bus_d  = blk_f;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d != ST_WARMUP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lfsr_q  <= '0;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      bus_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      bus_q   <= bus_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign rnd.seed_ready = ready_q;
  assign rnd.rnd_valid  = valid_q;
  assign rnd.seed_err   = err_q;
  assign rnd.rnd_bus0w  = bus_q[B0-1:0];
  assign rnd.rnd_bus1w  = bus_q[B0 +: B1];
  assign rnd.rnd_bus2w  = bus_q[B0+B1 +: B2];
  assign rnd.rnd_bus3w  = bus_q[B0+B1+B2 +: B3];
endmodule

// File: tb/tb_aes_sbox_rnd_gen.sv
// Self-checking bench for aes_sbox_rnd_gen: three parameterisations, a bit-stream LFSR model
// and a scoreboard of expected blocks.
`timescale 1ns/1ps
module tb_aes_sbox_rnd_gen;
  localparam int unsigned OW_A = 42, OW_B = 42, OW_C = 84;
  localparam int unsigned WARM_A = 0, WARM_B = 64, WARM_C = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  sel;
  logic        seed_valid_tb;
  logic        rnd_en_tb;
  logic [31:0] seed_in_tb;
  int          checks = 0;
  int          errors = 0;
  int unsigned cur_ow, cur_warm;

  always #5 clk = ~clk;

  aes_sbox_rnd_gen_if #(.D(2), .BLIND_BITS(24)) if_a ();
  aes_sbox_rnd_gen_if #(.D(2), .BLIND_BITS(24)) if_b ();
  aes_sbox_rnd_gen_if #(.D(3), .BLIND_BITS(30)) if_c ();

  assign if_a.seed_valid = seed_valid_tb && (sel == 2'd0);
  assign if_b.seed_valid = seed_valid_tb && (sel == 2'd1);
  assign if_c.seed_valid = seed_valid_tb && (sel == 2'd2);
  assign if_a.rnd_en     = rnd_en_tb && (sel == 2'd0);
  assign if_b.rnd_en     = rnd_en_tb && (sel == 2'd1);
  assign if_c.rnd_en     = rnd_en_tb && (sel == 2'd2);
  assign if_a.seed_in    = seed_in_tb;
  assign if_b.seed_in    = seed_in_tb;
  assign if_c.seed_in    = seed_in_tb;

  aes_sbox_rnd_gen #(.D(2), .BLIND_BITS(24), .WARMUP_CYC(WARM_A)) dut_a (.clk(clk), .rst(rst), .rnd(if_a));
  aes_sbox_rnd_gen #(.D(2), .BLIND_BITS(24), .WARMUP_CYC(WARM_B)) dut_b (.clk(clk), .rst(rst), .rnd(if_b));
  aes_sbox_rnd_gen #(.D(3), .BLIND_BITS(30), .WARMUP_CYC(WARM_C)) dut_c (.clk(clk), .rst(rst), .rnd(if_c));

  logic [127:0] obs_f;
  logic         obs_valid, obs_ready, obs_err;

  always_comb begin
    case (sel)
      2'd1: begin
        obs_f     = 128'({if_b.rnd_bus3w, if_b.rnd_bus2w, if_b.rnd_bus1w, if_b.rnd_bus0w});
        obs_valid = if_b.rnd_valid; obs_ready = if_b.seed_ready; obs_err = if_b.seed_err;
      end
      2'd2: begin
        obs_f     = 128'({if_c.rnd_bus3w, if_c.rnd_bus2w, if_c.rnd_bus1w, if_c.rnd_bus0w});
        obs_valid = if_c.rnd_valid; obs_ready = if_c.seed_ready; obs_err = if_c.seed_err;
      end
      default: begin
        obs_f     = 128'({if_a.rnd_bus3w, if_a.rnd_bus2w, if_a.rnd_bus1w, if_a.rnd_bus0w});
        obs_valid = if_a.rnd_valid; obs_ready = if_a.seed_ready; obs_err = if_a.seed_err;
      end
    endcase
  end

  // Model: the LFSR as a bit stream y[t] = y[t-128]^y[t-126]^y[t-101]^y[t-99], oldest bit at index 0.
  bit           hist[$];
  logic [127:0] exp_q[$];
  logic [127:0] ref_stream[$];
  logic [127:0] last_exp;

  function automatic void model_seed(input logic [127:0] s);
    hist.delete();
    for (int i = 127; i >= 0; i--) hist.push_back(s[i]);
  endfunction

  function automatic logic [127:0] model_block();
    logic [127:0] f;
    bit b;
    f = '0;
    for (int unsigned k = 0; k < cur_ow; k++) begin
      b    = hist[0] ^ hist[2] ^ hist[27] ^ hist[29];
      f[k] = b;
      void'(hist.pop_front());
      hist.push_back(b);
    end
    return f;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic use_inst(input logic [1:0] s);
    sel = s;
    case (s)
      2'd1:    begin cur_ow = OW_B; cur_warm = WARM_B; end
      2'd2:    begin cur_ow = OW_C; cur_warm = WARM_C; end
      default: begin cur_ow = OW_A; cur_warm = WARM_A; end
    endcase
  endtask

  task automatic do_seed(input logic [127:0] seed);
    for (int w = 0; w < 4; w++) begin
      int guard;
      guard = 0;
      seed_valid_tb = 1'b1;
      seed_in_tb    = seed[32*w +: 32];
      while (!obs_ready && guard < 200) begin
        tick;
        guard++;
      end
      if (guard >= 200) begin
        checks++; errors++;
        $display("FAIL seed_handshake word=%0d got ready=%b exp ready=1", w, obs_ready);
      end
      tick;
    end
    seed_valid_tb = 1'b0;
    seed_in_tb    = '0;
    model_seed((seed == '0) ? 128'h1 : seed);
    exp_q.delete();
  endtask

  // Waits for rnd_valid with rnd_en toggling (ignored outside RUN); buses must hold meanwhile.
  task automatic wait_valid(input string tag);
    logic [127:0] frozen;
    int unsigned  guard;
    frozen = obs_f;
    guard  = 0;
    while (guard < cur_warm + 10) begin
      rnd_en_tb = 1'($urandom_range(0, 1));
      tick;
      guard++;
      if (obs_valid) break;
      checks++;
      if (obs_f !== frozen) begin
        errors++;
        $display("FAIL %s_frozen got=%h exp=%h", tag, obs_f, frozen);
      end
    end
    rnd_en_tb = 1'b0;
    checks++;
    if (!obs_valid) begin
      errors++;
      $display("FAIL %s_timeout got valid=%b exp valid=1", tag, obs_valid);
    end else begin
      for (int unsigned k = 0; k < cur_warm; k++) void'(model_block());
      last_exp = model_block();
      if (obs_f !== last_exp) begin
        errors++;
        $display("FAIL %s_first_block got=%h exp=%h", tag, obs_f, last_exp);
      end
      checks++;
      if (guard != cur_warm + 1) begin
        errors++;
        $display("FAIL %s_latency got=%0d exp=%0d", tag, guard, cur_warm + 1);
      end
    end
  endtask

  task automatic run_stream(input int n, input bit rand_en, input bit rec, input bit cmp_ref, input string tag);
    for (int i = 0; i < n; i++) begin
      rnd_en_tb = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd_en_tb) exp_q.push_back(model_block());
      tick;
      if (rnd_en_tb) last_exp = exp_q.pop_front();
      checks++;
      if (obs_f !== last_exp || !obs_valid) begin
        errors++;
        $display("FAIL %s_blk%0d got=%h v=%b exp=%h v=1", tag, i, obs_f, obs_valid, last_exp);
      end
      if (rec) ref_stream.push_back(last_exp);
      if (cmp_ref) begin
        checks++;
        if (obs_f !== ref_stream[i+1]) begin
          errors++;
          $display("FAIL %s_ref%0d got=%h exp=%h", tag, i, obs_f, ref_stream[i+1]);
        end
      end
    end
    rnd_en_tb = 1'b0;
  endtask

  task automatic test_reset;
    use_inst(2'd0);
    rst = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    #1;
    checks++;
    if (obs_ready !== 1'b0 || obs_valid !== 1'b0 || obs_err !== 1'b0 || obs_f !== '0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b v=%b err=%b f=%h exp 0/0/0/0", obs_ready, obs_valid, obs_err, obs_f);
    end
    tick;
    checks++;
    if (obs_ready !== 1'b1 || obs_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b v=%b exp rdy=1 v=0", obs_ready, obs_valid);
    end
  endtask

  task automatic test_single_bit_seed;
    use_inst(2'd0);
    do_seed(128'h1);
    checks++;
    if (obs_valid !== 1'b0 || obs_ready !== 1'b0) begin
      errors++;
      $display("FAIL t2_warmup got v=%b rdy=%b exp v=0 rdy=0", obs_valid, obs_ready);
    end
    wait_valid("t2");
    checks++;
    if (obs_f !== '0) begin
      errors++;
      $display("FAIL t2_blk0_zero got=%h exp=0", obs_f);
    end
    ref_stream.delete();
    ref_stream.push_back(last_exp);
    run_stream(1, 1'b0, 1'b1, 1'b0, "t2a");
    checks++;
    if (obs_f !== '0) begin
      errors++;
      $display("FAIL t2_blk1_zero got=%h exp=0", obs_f);
    end
    run_stream(1, 1'b0, 1'b1, 1'b0, "t2b");
    checks++;
    if (obs_f === '0) begin
      errors++;
      $display("FAIL t2_blk2_nonzero got=%h exp=nonzero", obs_f);
    end
    run_stream(28, 1'b0, 1'b1, 1'b0, "t2c");
  endtask

  task automatic test_zero_seed;
    use_inst(2'd0);
    do_seed('0);
    checks++;
    if (obs_err !== 1'b1) begin
      errors++;
      $display("FAIL t3_err_set got=%b exp=1", obs_err);
    end
    wait_valid("t3");
    checks++;
    if (obs_f !== ref_stream[0]) begin
      errors++;
      $display("FAIL t3_ref0 got=%h exp=%h", obs_f, ref_stream[0]);
    end
    run_stream(29, 1'b0, 1'b0, 1'b1, "t3");
    do_seed({$urandom(), $urandom(), $urandom(), $urandom()} | 128'h8);
    checks++;
    if (obs_err !== 1'b0) begin
      errors++;
      $display("FAIL t3_err_clear got=%b exp=0", obs_err);
    end
    wait_valid("t3b");
    run_stream(5, 1'b1, 1'b0, 1'b0, "t3b");
    do_seed('0);
    wait_valid("t3c");
  endtask

  task automatic test_reset_mid_run;
    use_inst(2'd0);
    rnd_en_tb = 1'b1;
    tick;
    rst = 1'b1;
    #1;
    checks++;
    if (obs_ready !== 1'b0 || obs_valid !== 1'b0 || obs_err !== 1'b0 || obs_f !== '0) begin
      errors++;
      $display("FAIL midrun_reset got rdy=%b v=%b err=%b f=%h exp 0/0/0/0", obs_ready, obs_valid, obs_err, obs_f);
    end
    tick;
    rst = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_ready !== 1'b1 || obs_valid !== 1'b0 || obs_f !== '0) begin
        errors++;
        $display("FAIL midrun_idle%0d got rdy=%b v=%b f=%h exp 1/0/0", i, obs_ready, obs_valid, obs_f);
      end
      tick;
    end
    rnd_en_tb = 1'b0;
  endtask

  task automatic test_random_stream;
    use_inst(2'd1);
    do_seed({$urandom(), $urandom(), $urandom(), $urandom()});
    wait_valid("t4");
    run_stream(10000, 1'b1, 1'b0, 1'b0, "t4");
  endtask

  task automatic test_reseed_collision;
    logic [127:0] frozen, s;
    use_inst(2'd0);
    do_seed({$urandom(), $urandom(), $urandom(), $urandom()});
    wait_valid("t5pre");
    run_stream(3, 1'b0, 1'b0, 1'b0, "t5pre");
    frozen = obs_f;
    s = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (obs_ready !== 1'b1) begin
        errors++;
        $display("FAIL t5_ready%0d got=%b exp=1", w, obs_ready);
      end
      seed_valid_tb = 1'b1;
      seed_in_tb    = s[32*w +: 32];
      rnd_en_tb     = 1'b1;
      tick;
      checks++;
      if (obs_valid !== 1'b0 || obs_f !== frozen) begin
        errors++;
        $display("FAIL t5_frozen%0d got v=%b f=%h exp v=0 f=%h", w, obs_valid, obs_f, frozen);
      end
    end
    seed_valid_tb = 1'b0;
    rnd_en_tb     = 1'b0;
    model_seed(s);
    exp_q.delete();
    wait_valid("t5");
    run_stream(20, 1'b1, 1'b0, 1'b0, "t5");
  endtask

  task automatic test_back_to_back;
    logic [127:0] s1, s2;
    use_inst(2'd0);
    s1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    s2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    do_seed(s1);
    seed_valid_tb = 1'b1;
    seed_in_tb    = s2[31:0];
    #1;
    checks++;
    if (obs_ready !== 1'b0) begin
      errors++;
      $display("FAIL t7_stall got ready=%b exp=0", obs_ready);
    end
    tick;
    last_exp = model_block();
    checks++;
    if (obs_valid !== 1'b1 || obs_f !== last_exp) begin
      errors++;
      $display("FAIL t7_s1_block got v=%b f=%h exp v=1 f=%h", obs_valid, obs_f, last_exp);
    end
    do_seed(s2);
    wait_valid("t7");
    run_stream(20, 1'b1, 1'b0, 1'b0, "t7");
  endtask

  task automatic test_wide;
    logic [127:0] e;
    use_inst(2'd2);
    do_seed({$urandom(), $urandom(), $urandom(), $urandom()});
    wait_valid("t6");
    for (int i = 0; i < 16; i++) begin
      rnd_en_tb = 1'b1;
      e = model_block();
      tick;
      checks++;
      if (if_c.rnd_bus0w !== e[11:0] || if_c.rnd_bus1w !== e[17:12] ||
          if_c.rnd_bus2w !== e[59:18] || if_c.rnd_bus3w !== e[83:60]) begin
        errors++;
        $display("FAIL t6_slices%0d got=%h/%h/%h/%h exp=%h/%h/%h/%h", i,
                 if_c.rnd_bus0w, if_c.rnd_bus1w, if_c.rnd_bus2w, if_c.rnd_bus3w,
                 e[11:0], e[17:12], e[59:18], e[83:60]);
      end
    end
    rnd_en_tb = 1'b0;
  endtask

  initial begin
    sel           = 2'd0;
    seed_valid_tb = 1'b0;
    rnd_en_tb     = 1'b0;
    seed_in_tb    = '0;
    last_exp      = '0;
    test_reset;
    test_single_bit_seed;
    test_zero_seed;
    test_reset_mid_run;
    test_random_stream;
    test_reseed_collision;
    test_back_to_back;
    test_wide;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
